// File: rtl/ddr_wr_arbiter.sv
// rtl/ddr_wr_arbiter.sv - two-master arbiter onto one DDR3 Avalon-MM write port, burst-bounded grants.
// Optional fixed-priority mode (m0 never preempted by the burst limit): define ARB_FIXED_PRIO_EN.
module ddr_wr_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m0_write,
  input  logic [ADDR_W-1:0]        m0_addr,
  input  logic signed [DATA_W-1:0] m0_writedata,
  output logic                     m0_waitrequest,
  input  logic                     m1_write,
  input  logic [ADDR_W-1:0]        m1_addr,
  input  logic signed [DATA_W-1:0] m1_writedata,
  output logic                     m1_waitrequest,
  output logic                     ddr_write,
  output logic [ADDR_W-1:0]        ddr_addr,
  output logic signed [DATA_W-1:0] ddr_writedata,
  input  logic                     ddr_waitrequest,
  output logic [1:0]               grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT = 8'(MAX_BURST - 1);

  state_t     state, state_next;
  logic [7:0] beats, beats_next;
  logic       last, last_next;
  logic       acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beats <= 8'd0;
      last  <= 1'b1;
      grant <= 2'b00;
    end else begin
      state <= state_next;
      beats <= beats_next;
      last  <= last_next;
      grant <= {state_next == G1, state_next == G0};
    end
  end

  // Slave side follows the grant combinationally; masters hold commands while stalled.
  always_comb begin
    ddr_write     = 1'b0;
    ddr_addr      = '0;
    ddr_writedata = '0;
    case (state)
      G0: begin
        ddr_write     = m0_write;
        ddr_addr      = m0_addr;
        ddr_writedata = m0_writedata;
      end
      G1: begin
        ddr_write     = m1_write;
        ddr_addr      = m1_addr;
        ddr_writedata = m1_writedata;
      end
      default: ;
    endcase
  end

  assign m0_waitrequest = (state != G0) || ddr_waitrequest;
  assign m1_waitrequest = (state != G1) || ddr_waitrequest;
  assign acc            = ddr_write && !ddr_waitrequest;

  always_comb begin
    state_next = state;
    beats_next = beats;
    last_next  = last;
    case (state)
      IDLE: begin
        beats_next = 8'd0;
        if (m0_write && m1_write) begin
`ifdef ARB_FIXED_PRIO_EN
          state_next = G0;
`else
          state_next = last ? G0 : G1;
`endif
        end else if (m0_write) begin
          state_next = G0;
        end else if (m1_write) begin
          state_next = G1;
        end
      end
      G0: begin
        if (acc) begin
          if (beats == LIMIT) begin
            beats_next = 8'd0;
`ifndef ARB_FIXED_PRIO_EN
            if (m1_write) begin
              state_next = G1;
              last_next  = 1'b0;
            end
`endif
          end else begin
            beats_next = beats + 8'd1;
          end
        end else if (!m0_write) begin
          beats_next = 8'd0;
          last_next  = 1'b0;
          state_next = m1_write ? G1 : IDLE;
        end
      end
      G1: begin
        if (acc) begin
          if (beats == LIMIT) begin
            beats_next = 8'd0;
            if (m0_write) begin
              state_next = G0;
              last_next  = 1'b1;
            end
          end else begin
            beats_next = beats + 8'd1;
          end
        end else if (!m1_write) begin
          beats_next = 8'd0;
          last_next  = 1'b1;
          state_next = m0_write ? G0 : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        beats_next = 8'd0;
      end
    endcase
  end

endmodule
